// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles with a start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that selects a - b (a + ~b + 1).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [DIGIT:0]         digit_sum;
    logic [WIDTH+DIGIT-1:0] psum_cat;
    logic [WIDTH-1:0]       psum_shift;
    logic                   sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // One DIGIT-bit full-adder slice; the new digit enters the partial sum at its MSB end.
    assign digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign psum_cat   = {digit_sum[DIGIT-1:0], psum_q};
    assign psum_shift = psum_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    // Subtraction folds into the same slice: invert b and force the carry-in.
                    b_d     = sub_sel ? ~b : b;
                    carry_d = sub_sel ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_sum[DIGIT];
                psum_d  = psum_shift;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    sum_d   = psum_shift;
                    cout_d  = digit_sum[DIGIT];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; every register, operands included, is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/1, 8/4, 4/1) checked against an arithmetic model.
// Subtraction checks are compiled in when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st8, st84, st4;
    logic [7:0] a8, b8, a84, b84;
    logic [3:0] a4, b4;
    logic       c8, c84, c4, sub8;

    logic       busy8, done8, cout8;
    logic       busy84, done84, cout84;
    logic       busy4, done4, cout4;
    logic [7:0] sum8, sum84;
    logic [3:0] sum4;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .cin(c8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut84 (
        .clk(clk), .rst_n(rst_n), .start(st84), .a(a84), .b(b84), .cin(c84),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84)
    );

    serial_adder #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(c4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // Reference: {cout, sum} = a + b + cin (or a + ~b + 1), modulo 2^w.
    function automatic logic [8:0] ref_add(input int w, input logic [7:0] av, input logic [7:0] bv,
                                           input logic cv, input logic sv);
        int mask;
        int total;
        logic [8:0] r;
        mask = (1 << w) - 1;
        if (sv) total = (int'(av) & mask) + (mask - (int'(bv) & mask)) + 1;
        else    total = (int'(av) & mask) + (int'(bv) & mask) + int'(cv);
        r[7:0] = 8'(total & mask);
        r[8]   = total[w];
        return r;
    endfunction

    function automatic int width_of(input int which);
        return (which == 2) ? 4 : 8;
    endfunction

    function automatic int digits_of(input int which);
        return (which == 0) ? 8 : (which == 1) ? 2 : 4;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy8 : (which == 1) ? busy84 : busy4;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? done8 : (which == 1) ? done84 : done4;
    endfunction

    function automatic logic [7:0] get_sum(input int which);
        return (which == 0) ? sum8 : (which == 1) ? sum84 : {4'b0, sum4};
    endfunction

    function automatic logic get_cout(input int which);
        return (which == 0) ? cout8 : (which == 1) ? cout84 : cout4;
    endfunction

    task automatic drive(input int which, input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic sv);
        case (which)
            0: begin st8 = s; a8 = av; b8 = bv; c8 = cv; sub8 = sv; end
            1: begin st84 = s; a84 = av; b84 = bv; c84 = cv; end
            default: begin st4 = s; a4 = av[3:0]; b4 = bv[3:0]; c4 = cv; end
        endcase
    endtask

    // Issues one operation and returns at the negedge where done is seen (or after the budget).
    task automatic run_op(input int which, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv, input string name);
        logic [8:0] exp;
        int n;
        int lat;
        n   = digits_of(which);
        exp = ref_add(width_of(which), av, bv, cv, sv);
        @(negedge clk);
        drive(which, 1'b1, av, bv, cv, sv);
        @(negedge clk);
        drive(which, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (get_busy(which) !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_accept: got %0b want 1", name, get_busy(which));
        end
        lat = 0;
        for (int i = 1; i <= n + 4 && lat == 0; i++) begin
            @(negedge clk);
            if (get_done(which) === 1'b1) lat = i;
        end
        checks++;
        if (lat != n) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, n);
        end
        checks++;
        if (get_sum(which) !== exp[7:0] || get_cout(which) !== exp[8]) begin
            failures++;
            $display("FAIL %s result: got cout=%0b sum=%h want cout=%0b sum=%h",
                     name, get_cout(which), get_sum(which), exp[8], exp[7:0]);
        end
        checks++;
        if (get_busy(which) !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done: got %0b want 0", name, get_busy(which));
        end
    endtask

    task automatic test_reset();
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0 || get_sum(w) !== 8'h00 || get_cout(w) !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d: got busy=%0b done=%0b sum=%h cout=%0b want all 0",
                         w, get_busy(w), get_done(w), get_sum(w), get_cout(w));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, "wrap_ff_01");
    endtask

    task automatic test_back_to_back();
        int lat;
        bit held_ok;
        run_op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a_cin");
        // Still in the done cycle: the new start is accepted because the FSM is IDLE.
        drive(0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        lat = 0;
        held_ok = 1'b1;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            if (sum8 !== 8'h00 || cout8 !== 1'b1) held_ok = 1'b0;
            @(negedge clk);
            if (done8 === 1'b1) lat = i;
        end
        checks++;
        if (!held_ok) begin
            failures++;
            $display("FAIL b2b_hold: previous result not held during run (sum=%h cout=%0b)", sum8, cout8);
        end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL b2b_latency: got %0d want 8", lat);
        end
        checks++;
        if (sum8 !== 8'h46 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result: got cout=%0b sum=%h want cout=0 sum=46", cout8, sum8);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        logic [7:0] s_at_done;
        logic c_at_done;
        logic busy_late;
        lat = 0; extra = 0; s_at_done = 8'h00; c_at_done = 1'b0; busy_late = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                if (lat == 0) begin
                    lat = i; s_at_done = sum8; c_at_done = cout8;
                end else extra++;
            end
            if (i == 10) busy_late = busy8;
            if (i == 3) drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
            else if (i == 4) drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (lat != 8) begin
            failures++;
            $display("FAIL ignore_latency: got %0d want 8", lat);
        end
        checks++;
        if (s_at_done !== 8'h4B || c_at_done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: got cout=%0b sum=%h want cout=0 sum=4b", c_at_done, s_at_done);
        end
        checks++;
        if (extra != 0 || busy_late !== 1'b0) begin
            failures++;
            $display("FAIL ignore_extra: got extra_done=%0d busy=%0b want 0 and 0", extra, busy_late);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        int busy_seen;
        run_op(0, 8'h11, 8'h22, 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        drive(0, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run: got busy=%0b done=%0b sum=%h cout=%0b want all 0",
                     busy8, done8, sum8, cout8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0; busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0) seen++;
            if (busy8 !== 1'b0) busy_seen++;
        end
        checks++;
        if (seen != 0 || busy_seen != 0) begin
            failures++;
            $display("FAIL reset_idle_after: got done_cycles=%0d busy_cycles=%0d want 0 and 0", seen, busy_seen);
        end
    endtask

    task automatic test_digit4_and_random();
        logic [7:0] av, bv;
        logic cv;
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, "d4_7f_01");
        for (int k = 0; k < 16; k++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            cv = 1'($urandom_range(0, 1));
            run_op(k % 2, av, bv, cv, 1'b0, "random");
        end
    endtask

    task automatic test_exhaustive4();
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    run_op(2, 8'(ai), 8'(bi), 1'(ci), 1'b0, "exh4");
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
        checks++;
        if (sum8 !== 8'hFE || cout8 !== 1'b0) begin
            failures++;
            $display("FAIL sub_05_07_const: got cout=%0b sum=%h want cout=0 sum=fe", cout8, sum8);
        end
        run_op(0, 8'h07, 8'h05, 1'b1, 1'b1, "sub_07_05");
        checks++;
        if (sum8 !== 8'h02 || cout8 !== 1'b1) begin
            failures++;
            $display("FAIL sub_07_05_const: got cout=%0b sum=%h want cout=1 sum=02", cout8, sum8);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_digit4_and_random();
        test_exhaustive4();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
